// File: rtl/midi_pkg.sv
// Shared types and helpers for the multi-channel MIDI CC sender.
// Status nibble, FSM state encoding and the distance-to-CC scale factor.
package midi_pkg;

    localparam logic [3:0] CC_STATUS_NIB = 4'hB;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STATUS = 3'd2,
        ST_CTRL   = 3'd3,
        ST_VAL    = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    // floor(127 * 2^16 / (dmax - dmin)); evaluated at elaboration only
    function automatic logic [31:0] cc_scale(input int dmin, input int dmax);
        return (32'd127 << 16) / 32'(dmax - dmin);
    endfunction

endpackage

// File: rtl/midi_cc_multi_sender_distance_to_cc.sv
// Combinational distance-to-CC mapping: near distances give 127, far give 0,
// linear in between using a fixed-point reciprocal of the span.
module distance_to_cc
    import midi_pkg::*;
#(
    parameter int DW    = 16,
    parameter int D_MIN = 5,
    parameter int D_MAX = 60
) (
    input  logic [DW-1:0] i_dist,
    output logic [6:0]    o_val
);

    localparam logic [31:0] SCALE = cc_scale(D_MIN, D_MAX);
    localparam int          PW    = DW + 32;

    logic [DW-1:0] w_off;
    logic [PW-1:0] w_prod;
    logic [PW-1:0] w_shift;

    // Clamp at both ends, otherwise subtract the scaled offset from full scale
    always_comb begin
        w_off   = i_dist - DW'(D_MIN);
        w_prod  = PW'(w_off) * PW'(SCALE);
        w_shift = w_prod >> 16;
        if (i_dist <= DW'(D_MIN)) begin
            o_val = 7'd127;
        end else if (i_dist >= DW'(D_MAX)) begin
            o_val = 7'd0;
        end else begin
            o_val = 7'd127 - 7'(w_shift);
        end
    end

endmodule

// File: rtl/midi_cc_multi_sender.sv
// Multi-channel MIDI Control Change sender with round-robin arbitration and
// duplicate suppression. Optional MIDI_RUNNING_STATUS_EN omits repeated status bytes.
module midi_cc_multi_sender
    import midi_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int MIDI_CH = 0,
    parameter int CC_BASE = 7,
    parameter int D_MIN   = 5,
    parameter int D_MAX   = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] distance_cm,
    input  logic [NCH-1:0]    distance_ready,
    output logic [7:0]        midi_byte,
    output logic              midi_send,
    input  logic              uart_ready,
    output logic              busy
);

    localparam int          CW          = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0]  STATUS_BYTE = {CC_STATUS_NIB, 4'(MIDI_CH)};

    logic [DW-1:0]  r_shadow [NCH];
    logic [NCH-1:0] r_pending;
    logic [DW-1:0]  r_work;
    logic [CW-1:0]  r_grant;
    logic [CW-1:0]  r_rr;
    state_t         r_state;
    state_t         r_after;
    logic [6:0]     r_val;
    logic [7:0]     r_last_val [NCH];
    logic [7:0]     r_midi_byte;
    logic           r_midi_send;
`ifdef MIDI_RUNNING_STATUS_EN
    logic           r_status_sent;
`endif

    logic           w_found;
    logic [CW-1:0]  w_grant;
    int             w_idx;
    logic [6:0]     w_val;
    state_t         w_first;
    state_t         w_send_state;
    logic [7:0]     w_tx_byte;

    function automatic state_t next_byte_state(input state_t s);
        case (s)
            ST_STATUS: return ST_CTRL;
            ST_CTRL:   return ST_VAL;
            default:   return ST_IDLE;
        endcase
    endfunction

    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] g);
        if (int'(g) == NCH - 1) begin
            return '0;
        end else begin
            return g + CW'(1);
        end
    endfunction

    distance_to_cc #(
        .DW    (DW),
        .D_MIN (D_MIN),
        .D_MAX (D_MAX)
    ) u_map (
        .i_dist (r_work),
        .o_val  (w_val)
    );

    // Round-robin search: first pending channel at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = (int'(r_rr) + k) % NCH;
            if (!w_found && r_pending[w_idx]) begin
                w_found = 1'b1;
                w_grant = CW'(w_idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Select which byte is due: from LOAD the first byte may go out directly
    always_comb begin
`ifdef MIDI_RUNNING_STATUS_EN
        w_first = r_status_sent ? ST_CTRL : ST_STATUS;
`else
        w_first = ST_STATUS;
`endif
        w_send_state = (r_state == ST_LOAD) ? w_first : r_state;
        case (w_send_state)
            ST_STATUS: w_tx_byte = STATUS_BYTE;
            ST_CTRL:   w_tx_byte = {1'b0, 7'(CC_BASE) + 7'(r_grant)};
            ST_VAL:    w_tx_byte = {1'b0, r_val};
            default:   w_tx_byte = 8'd0;
        endcase
    end

    // Sample latching; a fresh strobe beats the grant clearing the same channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (distance_ready[i]) begin
                    r_shadow[i]  <= distance_cm[i*DW +: DW];
                    r_pending[i] <= 1'b1;
                end else if (r_state == ST_IDLE && w_found && int'(w_grant) == i) begin
                    r_pending[i] <= 1'b0;
                end else begin
                    r_pending[i] <= r_pending[i];
                end
            end
        end
    end

    // Message FSM with registered byte/strobe outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_after     <= ST_IDLE;
            r_rr        <= '0;
            r_grant     <= '0;
            r_work      <= '0;
            r_val       <= 7'd0;
            r_midi_byte <= 8'd0;
            r_midi_send <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_last_val[i] <= 8'hFF;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            r_status_sent <= 1'b0;
`endif
        end else begin
            r_midi_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_grant;
                        r_work  <= r_shadow[w_grant];
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_val <= w_val;
                    if ({1'b0, w_val} == r_last_val[r_grant]) begin
                        r_rr    <= rr_next(r_grant);
                        r_state <= ST_IDLE;
                    end else if (uart_ready) begin
                        r_midi_send <= 1'b1;
                        r_midi_byte <= w_tx_byte;
                        r_after     <= next_byte_state(w_first);
                        r_state     <= ST_GAP;
`ifdef MIDI_RUNNING_STATUS_EN
                        if (w_first == ST_STATUS) begin
                            r_status_sent <= 1'b1;
                        end else begin
                            r_status_sent <= r_status_sent;
                        end
`endif
                    end else begin
                        r_state <= w_first;
                    end
                end
                ST_STATUS, ST_CTRL, ST_VAL: begin
                    if (uart_ready) begin
                        r_midi_send <= 1'b1;
                        r_midi_byte <= w_tx_byte;
                        r_after     <= next_byte_state(r_state);
                        r_state     <= ST_GAP;
`ifdef MIDI_RUNNING_STATUS_EN
                        if (r_state == ST_STATUS) begin
                            r_status_sent <= 1'b1;
                        end else begin
                            r_status_sent <= r_status_sent;
                        end
`endif
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_GAP: begin
                    r_state <= r_after;
                    if (r_after == ST_IDLE) begin
                        r_last_val[r_grant] <= {1'b0, r_val};
                        r_rr                <= rr_next(r_grant);
                    end else begin
                        r_rr <= r_rr;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign midi_byte = r_midi_byte;
    assign midi_send = r_midi_send;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_midi_cc_multi_sender.sv
// Self-checking bench for midi_cc_multi_sender: expected byte stream is built
// from the CC mapping formula and protocol rules, then checked on every send.
module tb_midi_cc_multi_sender;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH*DW-1:0] distance_cm = '0;
    logic [NCH-1:0]    distance_ready = '0;
    logic [7:0]        midi_byte;
    logic              midi_send;
    logic              uart_ready = 1'b1;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int n_sends = 0;
    logic [7:0] exp_q [$];
    bit  model_status_sent = 1'b0;

    midi_cc_multi_sender dut (
        .clk            (clk),
        .rst            (rst),
        .distance_cm    (distance_cm),
        .distance_ready (distance_ready),
        .midi_byte      (midi_byte),
        .midi_send      (midi_send),
        .uart_ready     (uart_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int cc_model(input int d);
        int scale;
        scale = (127 * 65536) / (60 - 5);
        if (d <= 5) return 127;
        if (d >= 60) return 0;
        return 127 - ((d - 5) * scale) / 65536;
    endfunction

    task automatic expect_msg(input int ch, input int val);
`ifdef MIDI_RUNNING_STATUS_EN
        if (!model_status_sent) exp_q.push_back(8'hB0);
`else
        exp_q.push_back(8'hB0);
`endif
        model_status_sent = 1'b1;
        exp_q.push_back(8'(7 + ch));
        exp_q.push_back(8'(val));
    endtask

    task automatic strobe(input int ch, input int d);
        @(negedge clk);
        distance_cm[ch*DW +: DW] = 16'(d);
        distance_ready = NCH'(1) << ch;
        @(negedge clk);
        distance_ready = '0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 1000, {name, "_timeout"}, n, 1000);
        chk(exp_q.size() == 0, {name, "_queue_empty"}, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_send(input string name);
        int n = 0;
        int s0 = n_sends;
        while (n_sends == s0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, {name, "_send_timeout"}, n, 200);
    endtask

    // Per-cycle compare: byte order, hold-after-send, no back-to-back, uart_ready respected
    initial begin
        logic       prev_send = 1'b0;
        logic [7:0] last_byte = 8'd0;
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk(midi_send == 1'b0, "rst_send", int'(midi_send), 0);
                chk(busy == 1'b0, "rst_busy", int'(busy), 0);
                chk(midi_byte == 8'd0, "rst_byte", int'(midi_byte), 0);
                last_byte = 8'd0;
                prev_send = 1'b0;
            end else begin
                if (midi_send) begin
                    n_sends++;
                    chk(!prev_send, "back_to_back", int'(prev_send), 0);
                    chk(uart_ready == 1'b1, "send_while_not_ready", int'(uart_ready), 1);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_send", int'(midi_byte), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk(midi_byte == e, "byte", int'(midi_byte), int'(e));
                    end
                    last_byte = midi_byte;
                end else begin
                    chk(midi_byte == last_byte, "byte_hold", int'(midi_byte), int'(last_byte));
                end
                prev_send = midi_send;
            end
        end
    end

    initial begin
        int s0;
        int lat;
        bit busy_seen;

        // Model pinned against hand-computed values
        chk(cc_model(20) == 93, "model_d20", cc_model(20), 93);
        chk(cc_model(5) == 127, "model_d5", cc_model(5), 127);
        chk(cc_model(60) == 0, "model_d60", cc_model(60), 0);
        chk(cc_model(3) == 127, "model_d3", cc_model(3), 127);
        chk(cc_model(59) == 3, "model_d59", cc_model(59), 3);
        chk(cc_model(10) == 116, "model_d10", cc_model(10), 116);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single message, latency 3 cycles
        expect_msg(0, cc_model(20));
        s0 = n_sends;
        @(negedge clk);
        distance_cm[0 +: DW] = 16'd20;
        distance_ready = 4'b0001;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            distance_ready = '0;
            if (midi_send && lat == 0) lat = c;
        end
        chk(lat == 3, "latency", lat, 3);
        wait_done("t1");
        chk(n_sends - s0 == 3, "t1_send_count", n_sends - s0, 3);

        // 2: clamps and re-send of the same value after a different one
        expect_msg(0, 127); strobe(0, 5);  wait_done("t2a");
        expect_msg(0, 0);   strobe(0, 60); wait_done("t2b");
        expect_msg(0, 127); strobe(0, 3);  wait_done("t2c");

        // 4: duplicate value dropped, busy still pulses
        expect_msg(0, 93); strobe(0, 20); wait_done("t4a");
        s0 = n_sends;
        busy_seen = 1'b0;
        strobe(0, 20);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        chk(n_sends == s0, "t4_dup_suppressed", n_sends - s0, 0);
        chk(busy_seen, "t4_busy_pulse", int'(busy_seen), 1);

        // 3: simultaneous strobes served in round-robin order
        expect_msg(1, cc_model(10));
        expect_msg(2, cc_model(30));
        expect_msg(3, cc_model(50));
        @(negedge clk);
        distance_cm[1*DW +: DW] = 16'd10;
        distance_cm[2*DW +: DW] = 16'd30;
        distance_cm[3*DW +: DW] = 16'd50;
        distance_ready = 4'b1110;
        @(negedge clk);
        distance_ready = '0;
        wait_done("t3");

        // 5: UART stalls for 50 cycles mid-message
        expect_msg(1, cc_model(40));
        strobe(1, 40);
        wait_send("t5");
        @(negedge clk);
        uart_ready = 1'b0;
        s0 = n_sends;
        repeat (50) @(negedge clk);
        chk(n_sends == s0, "t5_held_off", n_sends - s0, 0);
        uart_ready = 1'b1;
        wait_done("t5");

        // 6: reset while waiting to send the controller byte
        exp_q.push_back(8'hB0);
        strobe(2, 45);
        wait_send("t6");
        @(negedge clk);
        uart_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_status_sent = 1'b0;
        uart_ready = 1'b1;
        s0 = n_sends;
        repeat (30) @(negedge clk);
        chk(n_sends == s0, "t6_no_send_after_rst", n_sends - s0, 0);
        chk(busy == 1'b0, "t6_idle_after_rst", int'(busy), 0);
        s0 = n_sends;
        expect_msg(2, cc_model(45)); strobe(2, 45); wait_done("t6a");
        chk(n_sends - s0 == 3, "t6_first_len", n_sends - s0, 3);
        s0 = n_sends;
        expect_msg(3, cc_model(7));  strobe(3, 7);  wait_done("t6b");
`ifdef MIDI_RUNNING_STATUS_EN
        chk(n_sends - s0 == 2, "t6_second_len", n_sends - s0, 2);
`else
        chk(n_sends - s0 == 3, "t6_second_len", n_sends - s0, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
